// File: rtl/timer_regs_pkg.sv
// Register map and control-word layout of the shared Avalon-MM interval timer,
// plus the state encoding of the scheduler that programs it.
package timer_regs_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD_L = 3'd2;
  localparam logic [2:0] REG_PERIOD_H = 3'd3;
  localparam logic [2:0] REG_SNAP_L   = 3'd4;
  localparam logic [2:0] REG_SNAP_H   = 3'd5;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  // One-shot start with interrupt enabled; stop with interrupt masked.
  localparam logic [15:0] CTRL_WORD_START = 16'((1 << CTRL_START) | (1 << CTRL_ITO));
  localparam logic [15:0] CTRL_WORD_STOP  = 16'(1 << CTRL_STOP);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_PL,
    ST_PH,
    ST_GAP,
    ST_START,
    ST_WAIT,
    ST_STOP,
    ST_ACK,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping around the request vector.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          valid_o
);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise a latch is inferred for the held value.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/timer_rr_scheduler.sv
// Round-robin scheduler that multiplexes one-shot timeouts for N_REQ requesters
// onto a single Avalon-MM interval timer through its write-only slave port.
module timer_rr_scheduler
  import timer_regs_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PER_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*PER_W-1:0] period,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       aborted,
  output logic                   busy,
  output logic [2:0]             grant_id,
  output logic [2:0]             avm_address,
  output logic                   avm_chipselect,
  output logic                   avm_write_n,
  output logic [15:0]            avm_writedata,
  input  logic                   timer_irq
);

  localparam int IW = $clog2(N_REQ);

  sched_state_e state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gid_q, gid_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             abort_q, abort_d;

  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] aborted_q, aborted_d;
  logic             busy_q, busy_d;
  logic [2:0]       addr_q, addr_d;
  logic             cs_q, cs_d;
  logic             write_n_q, write_n_d;
  logic [15:0]      wdata_q, wdata_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i       (req),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .valid_o     (arb_valid)
  );

  // Next-state logic: one bus write (or idle slot) per state, one cycle each.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gid_d    = gid_q;
    period_d = period_q;
    abort_d  = abort_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gid_d    = arb_idx;
          ptr_d    = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
          period_d = period[int'(arb_idx)*PER_W +: PER_W];
          abort_d  = 1'b0;
          state_d  = (period_d == '0) ? ST_DONE : ST_CLR;
        end
      end
      ST_CLR:   state_d = ST_PL;
      ST_PL:    state_d = ST_PH;
      ST_PH:    state_d = ST_GAP;
      ST_GAP:   state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // Expiry takes priority over a simultaneous request drop.
        if (timer_irq) begin
          state_d = ST_ACK;
        end else if (!req[gid_q]) begin
          abort_d = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP:  state_d = ST_ACK;
      ST_ACK:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: outputs are decoded from the next state and then registered, so the
  // bus write for a state is on the pins exactly while the FSM sits in it.
  always_comb begin
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    addr_d    = REG_STATUS;
    wdata_d   = '0;
    done_d    = '0;
    aborted_d = '0;
    busy_d    = (state_d != ST_IDLE);
    unique case (state_d)
      ST_CLR, ST_ACK: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = REG_STATUS;
        wdata_d   = 16'h0000;
      end
      ST_PL: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = REG_PERIOD_L;
        wdata_d   = period_d[15:0];
      end
      ST_PH: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = REG_PERIOD_H;
        wdata_d   = period_d[PER_W-1:16];
      end
      ST_START: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = REG_CONTROL;
        wdata_d   = CTRL_WORD_START;
      end
      ST_STOP: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = REG_CONTROL;
        wdata_d   = CTRL_WORD_STOP;
      end
      ST_DONE: begin
        if (abort_d) aborted_d[gid_d] = 1'b1;
        else         done_d[gid_d]    = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gid_q     <= '0;
      period_q  <= '0;
      abort_q   <= 1'b0;
      done_q    <= '0;
      aborted_q <= '0;
      busy_q    <= 1'b0;
      addr_q    <= '0;
      cs_q      <= 1'b0;
      write_n_q <= 1'b1;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gid_q     <= gid_d;
      period_q  <= period_d;
      abort_q   <= abort_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      write_n_q <= write_n_d;
      wdata_q   <= wdata_d;
    end
  end

  assign done           = done_q;
  assign aborted        = aborted_q;
  assign busy           = busy_q;
  assign grant_id       = 3'(gid_q);
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = write_n_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_rr_scheduler.sv
// Bench for timer_rr_scheduler: behavioural interval-timer slave plus a
// transaction-level round-robin reference model, directed and random services.
module tb_timer_rr_scheduler;
  import timer_regs_pkg::*;

  localparam int N  = 4;
  localparam int PW = 32;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*PW-1:0] period;
  logic [N-1:0]    done, aborted;
  logic            busy;
  logic [2:0]      grant_id, avm_address;
  logic            avm_chipselect, avm_write_n;
  logic [15:0]     avm_writedata;
  logic            timer_irq;

  int n_vec = 0;
  int n_err = 0;
  int model_ptr = 0;

  timer_rr_scheduler #(.N_REQ(N), .PER_W(PW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .period         (period),
    .done           (done),
    .aborted        (aborted),
    .busy           (busy),
    .grant_id       (grant_id),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .timer_irq      (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural one-shot interval timer reacting to the scheduler's writes.
  logic [31:0] tm_period;
  logic        tm_run, tm_to, tm_ito;
  int          tm_cnt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tm_period <= '0; tm_run <= 1'b0; tm_to <= 1'b0; tm_ito <= 1'b0; tm_cnt <= 0;
    end else if (avm_chipselect && !avm_write_n) begin
      case (avm_address)
        REG_STATUS:   tm_to <= 1'b0;
        REG_CONTROL: begin
          tm_ito <= avm_writedata[CTRL_ITO];
          if (avm_writedata[CTRL_STOP]) tm_run <= 1'b0;
          else if (avm_writedata[CTRL_START]) begin
            tm_run <= 1'b1;
            tm_cnt <= int'(tm_period) + 1;
          end
        end
        REG_PERIOD_L: tm_period[15:0] <= avm_writedata;
        REG_PERIOD_H: begin
          tm_period[31:16] <= avm_writedata;
          tm_run           <= 1'b0;
        end
        default: ;
      endcase
    end else if (tm_run) begin
      if (tm_cnt == 0) begin
        tm_to  <= 1'b1;
        tm_run <= 1'b0;
      end else begin
        tm_cnt <= tm_cnt - 1;
      end
    end
  end

  assign timer_irq = tm_to & tm_ito;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] rand_period();
    if ($urandom_range(0, 3) == 0) return 32'd0;
    return 32'($urandom_range(1, 40));
  endfunction

  // One complete service. mode 0: hold req until done; 1: drop req drop_delay
  // cycles after the start write; 2: drop req the cycle irq is first seen.
  task automatic serve(input int mode, input int drop_delay);
    int          g, cyc, start_cyc, irq_cyc, drop_at;
    logic [31:0] p;
    bit          fin, seen_busy, exp_abort;
    logic [2:0]  wa[$], ea[$];
    logic [15:0] wd[$], ed[$];
    int          wc[$];
    g = rr_pick(req, model_ptr);
    if (g < 0) return;
    p = period[g*PW +: PW];
    model_ptr = (g + 1) % N;
    exp_abort = (mode == 1) && (p != 0);
    if (p != 0) begin
      ea = '{REG_STATUS, REG_PERIOD_L, REG_PERIOD_H, REG_CONTROL};
      ed = '{16'h0000, p[15:0], p[31:16], 16'h0005};
      if (exp_abort) begin
        ea.push_back(REG_CONTROL); ed.push_back(16'h0008);
      end
      ea.push_back(REG_STATUS); ed.push_back(16'h0000);
    end
    fin = 0; seen_busy = 0; cyc = 0; start_cyc = -1; irq_cyc = -1; drop_at = -1;
    while (!fin && cyc < int'(p) + 64) begin
      @(negedge clk);
      cyc++;
      if (busy && !seen_busy) begin
        seen_busy = 1;
        check("grant_id", 64'(grant_id), 64'(g));
      end
      if (avm_chipselect) begin
        check("write_n", 64'(avm_write_n), 64'd0);
        wa.push_back(avm_address); wd.push_back(avm_writedata); wc.push_back(cyc);
        if (avm_address == REG_CONTROL && avm_writedata == 16'h0005) start_cyc = cyc;
        // Requester is free to change its period once granted.
        period[g*PW +: PW] = $urandom;
      end
      if (timer_irq && irq_cyc < 0 && start_cyc >= 0) irq_cyc = cyc;
      if (mode == 1 && start_cyc >= 0 && drop_at < 0) drop_at = start_cyc + drop_delay;
      if (mode == 1 && cyc == drop_at) req[g] = 1'b0;
      if (mode == 2 && irq_cyc == cyc) req[g] = 1'b0;
      if (done != '0 || aborted != '0) fin = 1;
    end
    check("svc_finished", 64'(fin), 64'd1);
    check("done", 64'(done), exp_abort ? 64'd0 : 64'd1 << g);
    check("aborted", 64'(aborted), exp_abort ? 64'd1 << g : 64'd0);
    check("n_writes", 64'(wa.size()), 64'(ea.size()));
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      check("wr_addr", 64'(wa[i]), 64'(ea[i]));
      check("wr_data", 64'(wd[i]), 64'(ed[i]));
    end
    if (p == 0) check("zero_latency", 64'(cyc <= 2), 64'd1);
    if (p != 0 && wc.size() >= 4) begin
      check("wr_spacing", 64'(wc[2] - wc[0]), 64'd2);
      check("gap_before_start", 64'(wc[3] - wc[2]), 64'd2);
    end
    if (p != 0 && !exp_abort) begin
      check("irq_latency", 64'(irq_cyc - start_cyc), 64'(p + 3));
      check("done_after_irq", 64'(cyc - irq_cyc), 64'd2);
    end
    req[g] = 1'b0;
    @(negedge clk);
    check("pulse_width", 64'(done | aborted), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    period  = '0;
    repeat (2) @(negedge clk);
    check("rst_outputs", 64'({done, aborted, busy, grant_id, avm_address,
                              avm_chipselect, avm_write_n, avm_writedata}), 64'h1_0000);
    reset_n   = 1'b1;
    model_ptr = 0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // All four requesting from reset: served 0,1,2,3.
    req = 4'b1111;
    for (int i = 0; i < N; i++) period[i*PW +: PW] = 32'd5;
    for (int i = 0; i < N; i++) serve(0, 0);

    req = 4'b0001; period[0 +: PW] = 32'h0000_0010;
    serve(0, 0);

    req = 4'b0100; period[2*PW +: PW] = 32'd0;
    serve(0, 0);

    req = 4'b0010; period[1*PW +: PW] = 32'd1000;
    serve(1, 100);

    req = 4'b1000; period[3*PW +: PW] = 32'd20;
    serve(2, 0);

    req = 4'b0001; period[0 +: PW] = 32'h0002_0010;
    serve(1, 5);

    // Reset while waiting on the timer.
    req = 4'b0010; period[1*PW +: PW] = 32'd200;
    model_ptr = (rr_pick(req, model_ptr) + 1) % N;
    begin
      int k;
      k = 0;
      while (!(avm_chipselect && avm_address == REG_CONTROL) && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("reach_start", 64'(k < 50), 64'd1);
    end
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("async_rst_outputs", 64'({done, aborted, busy, grant_id, avm_address,
                                    avm_chipselect, avm_write_n, avm_writedata}), 64'h1_0000);
    req = '0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n   = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    req = 4'b1010;
    period[1*PW +: PW] = 32'd3;
    period[3*PW +: PW] = 32'd4;
    serve(0, 0);
    serve(0, 0);

    // Random rounds with late arrivals competing for the next grant.
    for (int r = 0; r < 25; r++) begin
      int nsvc;
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) period[i*PW +: PW] = rand_period();
      nsvc = 0;
      while (req != '0) begin
        int          m, dd, gg, b;
        logic [31:0] pp;
        gg = rr_pick(req, model_ptr);
        pp = period[gg*PW +: PW];
        m  = $urandom_range(0, 2);
        dd = 0;
        if (pp < 8) m = 0;
        else dd = $urandom_range(1, int'(pp) - 1);
        serve(m, dd);
        nsvc++;
        if (nsvc < 6 && $urandom_range(0, 2) == 0) begin
          b = $urandom_range(0, N - 1);
          if (!req[b]) begin
            req[b] = 1'b1;
            period[b*PW +: PW] = rand_period();
          end
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
